cam_fill_ctrl: RTL and testbench

Allocation and fill controller that drives the update port of a CAM (TLB/tag CAM).
- Accepts fill requests after a lookup miss.
- Picks a slot: lowest-index free entry first, otherwise the tree pseudo-LRU victim.
- Tracks recency from lookup hits; handles single-entry invalidates and a full flush sequence.
- Outputs connect directly to the CAM's update_en/update_key/update_idx/update_valid.

---
 rtl/cam_fill_ctrl_pkg.sv | 26 ++
 rtl/cam_plru.sv | 70 +++++++
 rtl/cam_fill_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cam_fill_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_fill_ctrl_pkg.sv
// cam_fill_ctrl_pkg
// Shared definitions for the CAM fill/allocation controller.
//   state_t        : controller FSM states (IDLE, FLUSH)
//   MAX_ENTRIES    : widest one-hot vector accepted by onehot_to_idx
//   onehot_to_idx  : converts a one-hot (or all-zero) vector to a binary index
package cam_fill_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int unsigned MAX_ENTRIES = 64;

  // OR-ing the positions of set bits is exact for one-hot input and
  // avoids a priority chain; an all-zero input yields index 0.
  function automatic int unsigned onehot_to_idx(input logic [MAX_ENTRIES-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_ENTRIES; i++) begin
      if (oh[i]) idx = idx | unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cam_plru.sv
// cam_plru
// Tree pseudo-LRU state for NUM_ENTRIES slots (NUM_ENTRIES-1 node bits).
// Node 0 is the root, node n has children 2n+1 / 2n+2, leaves map to
// entries left to right. A node bit of 0 means the victim is on the left.
// Ports:
//   clk, reset     : clock, synchronous active-low reset (tree cleared)
//   clear          : clear the whole tree this edge (wins over updates)
//   touch_en/idx   : first MRU update applied this edge
//   fill_en/idx    : second MRU update, applied after touch (wins on shared nodes)
//   victim_idx     : current victim from the pre-edge tree
module cam_plru #(
  parameter int NUM_ENTRIES = 4,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   touch_en,
  input  logic [INDEX_WIDTH-1:0] touch_idx,
  input  logic                   fill_en,
  input  logic [INDEX_WIDTH-1:0] fill_idx,
  output logic [INDEX_WIDTH-1:0] victim_idx
);

  localparam int NODES = NUM_ENTRIES - 1;

  logic [NODES-1:0] r_tree;
  logic [NODES-1:0] w_tree_nxt;

  // Walk the entry's path from the root, pointing every node away from it.
  function automatic logic [NODES-1:0] mark_mru(input logic [NODES-1:0]       tree,
                                                input logic [INDEX_WIDTH-1:0] entry);
    logic [NODES-1:0] t;
    int               node;
    logic             dir;
    t    = tree;
    node = 0;
    for (int lvl = 0; lvl < INDEX_WIDTH; lvl++) begin
      dir     = entry[INDEX_WIDTH-1-lvl];
      t[node] = ~dir;
      node    = 2 * node + (dir ? 2 : 1);
    end
    return t;
  endfunction

  always_comb begin
    int node;
    node = 0;
    for (int lvl = 0; lvl < INDEX_WIDTH; lvl++) begin
      node = 2 * node + (r_tree[node] ? 2 : 1);
    end
    victim_idx = INDEX_WIDTH'(node - NODES);
  end

  always_comb begin
    w_tree_nxt = r_tree;
    if (clear) begin
      w_tree_nxt = '0;
    end else begin
      if (touch_en) w_tree_nxt = mark_mru(w_tree_nxt, touch_idx);
      if (fill_en)  w_tree_nxt = mark_mru(w_tree_nxt, fill_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_tree <= '0;
    else        r_tree <= w_tree_nxt;
  end

endmodule

// File: rtl/cam_fill_ctrl.sv
// cam_fill_ctrl
// Allocation and fill controller driving a CAM update port.
// Ports:
//   clk, reset              : clock, synchronous active-low reset
//   fill_req/fill_key       : fill request; accepted when fill_req && fill_ready
//   fill_ready              : combinational accept (IDLE, no flush/inval this cycle)
//   fill_idx                : slot chosen for the last accepted fill
//   touch_en/touch_idx      : lookup hit, refreshes recency in IDLE
//   inval_en/inval_idx      : invalidate one slot
//   flush_req / flush_busy  : invalidate all slots / sequence in progress
//   update_en/key/idx/valid : registered CAM update port
// Slot choice: lowest-index free slot, otherwise the tree-PLRU victim.
module cam_fill_ctrl
  import cam_fill_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fill_req,
  input  logic [KEY_WIDTH-1:0]   fill_key,
  output logic                   fill_ready,
  output logic [INDEX_WIDTH-1:0] fill_idx,
  input  logic                   touch_en,
  input  logic [INDEX_WIDTH-1:0] touch_idx,
  input  logic                   inval_en,
  input  logic [INDEX_WIDTH-1:0] inval_idx,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   update_en,
  output logic [KEY_WIDTH-1:0]   update_key,
  output logic [INDEX_WIDTH-1:0] update_idx,
  output logic                   update_valid
);

  state_t                 r_state,        w_state_nxt;
  logic [NUM_ENTRIES-1:0] r_valid,        w_valid_nxt;
  logic [INDEX_WIDTH-1:0] r_flush_cnt,    w_flush_cnt_nxt;
  logic                   r_update_en,    w_update_en_nxt;
  logic                   r_update_valid, w_update_valid_nxt;
  logic [KEY_WIDTH-1:0]   r_update_key,   w_update_key_nxt;
  logic [INDEX_WIDTH-1:0] r_update_idx,   w_update_idx_nxt;
  logic [INDEX_WIDTH-1:0] r_fill_idx,     w_fill_idx_nxt;

  logic                   w_fill_ready;
  logic                   w_fill_acc;
  logic [NUM_ENTRIES-1:0] w_free;
  logic [NUM_ENTRIES-1:0] w_free_low_oh;
  logic [MAX_ENTRIES-1:0] w_free_low_ext;
  logic [INDEX_WIDTH-1:0] w_free_idx;
  logic [INDEX_WIDTH-1:0] w_plru_victim;
  logic [INDEX_WIDTH-1:0] w_victim;
  logic                   w_plru_clear;
  logic                   w_plru_touch;
  logic                   w_plru_fill;

  assign w_fill_ready = (r_state == ST_IDLE) && !flush_req && !inval_en && reset;
  assign w_fill_acc   = fill_req && w_fill_ready;

  // x & -x isolates the lowest set bit of the free mask.
  assign w_free         = ~r_valid;
  assign w_free_low_oh  = w_free & (~w_free + NUM_ENTRIES'(1));
  assign w_free_low_ext = MAX_ENTRIES'(w_free_low_oh);
  assign w_free_idx     = INDEX_WIDTH'(onehot_to_idx(w_free_low_ext));
  assign w_victim       = (|w_free) ? w_free_idx : w_plru_victim;

  cam_plru #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_plru (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_plru_clear),
    .touch_en   (w_plru_touch),
    .touch_idx  (touch_idx),
    .fill_en    (w_plru_fill),
    .fill_idx   (w_victim),
    .victim_idx (w_plru_victim)
  );

  always_comb begin
    w_state_nxt        = r_state;
    w_valid_nxt        = r_valid;
    w_flush_cnt_nxt    = r_flush_cnt;
    w_update_en_nxt    = 1'b0;
    w_update_valid_nxt = r_update_valid;
    w_update_key_nxt   = r_update_key;
    w_update_idx_nxt   = r_update_idx;
    w_fill_idx_nxt     = r_fill_idx;
    w_plru_clear       = 1'b0;
    w_plru_touch       = 1'b0;
    w_plru_fill        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_plru_touch = touch_en;
        if (flush_req) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = '0;
        end else if (inval_en) begin
          w_update_en_nxt        = 1'b1;
          w_update_valid_nxt     = 1'b0;
          w_update_key_nxt       = '0;
          w_update_idx_nxt       = inval_idx;
          w_valid_nxt[inval_idx] = 1'b0;
        end else if (w_fill_acc) begin
          w_update_en_nxt       = 1'b1;
          w_update_valid_nxt    = 1'b1;
          w_update_key_nxt      = fill_key;
          w_update_idx_nxt      = w_victim;
          w_fill_idx_nxt        = w_victim;
          w_valid_nxt[w_victim] = 1'b1;
          w_plru_fill           = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_update_en_nxt    = 1'b1;
        w_update_valid_nxt = 1'b0;
        w_update_key_nxt   = '0;
        w_update_idx_nxt   = r_flush_cnt;
        w_flush_cnt_nxt    = r_flush_cnt + INDEX_WIDTH'(1);
        if (r_flush_cnt == INDEX_WIDTH'(NUM_ENTRIES - 1)) begin
          w_state_nxt  = ST_IDLE;
          w_valid_nxt  = '0;
          w_plru_clear = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_valid        <= '0;
      r_flush_cnt    <= '0;
      r_update_en    <= 1'b0;
      r_update_valid <= 1'b0;
      r_update_key   <= '0;
      r_update_idx   <= '0;
      r_fill_idx     <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_valid        <= w_valid_nxt;
      r_flush_cnt    <= w_flush_cnt_nxt;
      r_update_en    <= w_update_en_nxt;
      r_update_valid <= w_update_valid_nxt;
      r_update_key   <= w_update_key_nxt;
      r_update_idx   <= w_update_idx_nxt;
      r_fill_idx     <= w_fill_idx_nxt;
    end
  end

  assign fill_ready   = w_fill_ready;
  assign fill_idx     = r_fill_idx;
  assign flush_busy   = (r_state == ST_FLUSH);
  assign update_en    = r_update_en;
  assign update_valid = r_update_valid;
  assign update_key   = r_update_key;
  assign update_idx   = r_update_idx;

  // A requester stalled by fill_ready must keep its key steady.
  a_fill_key_stable: assert property (@(posedge clk) disable iff (!reset)
    (fill_req && !fill_ready) |=> (!fill_req || $stable(fill_key)));

endmodule

// File: tb/tb_cam_fill_ctrl.sv
module tb_cam_fill_ctrl;

  localparam int N  = 4;
  localparam int KW = 32;
  localparam int IW = 2;

  logic          clk;
  logic          reset;
  logic          fill_req;
  logic [KW-1:0] fill_key;
  logic          fill_ready;
  logic [IW-1:0] fill_idx;
  logic          touch_en;
  logic [IW-1:0] touch_idx;
  logic          inval_en;
  logic [IW-1:0] inval_idx;
  logic          flush_req;
  logic          flush_busy;
  logic          update_en;
  logic [KW-1:0] update_key;
  logic [IW-1:0] update_idx;
  logic          update_valid;

  cam_fill_ctrl #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .INDEX_WIDTH(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .fill_req     (fill_req),
    .fill_key     (fill_key),
    .fill_ready   (fill_ready),
    .fill_idx     (fill_idx),
    .touch_en     (touch_en),
    .touch_idx    (touch_idx),
    .inval_en     (inval_en),
    .inval_idx    (inval_idx),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .update_en    (update_en),
    .update_key   (update_key),
    .update_idx   (update_idx),
    .update_valid (update_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic [KW-1:0] key;
    logic          vld;
    logic          chk_fill;
  } exp_t;

  typedef struct {
    int          tag;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  exp_t sb[$];
  chk_t cq[$];
  exp_t e_cur;
  chk_t c_cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic string tag_name(input int t);
    case (t)
      0:       return "rst_update_en";
      1:       return "rst_update_valid";
      2:       return "rst_update_idx";
      3:       return "rst_update_key";
      4:       return "rst_fill_idx";
      5:       return "rst_flush_busy";
      6:       return "rst_fill_ready";
      7:       return "fill_ready";
      8:       return "flush_busy";
      9:       return "update_en";
      10:      return "sb_drain";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: the only process that counts and judges comparisons.
  always @(negedge clk) begin
    while (cq.size() > 0) begin
      c_cur = cq.pop_front();
      n_tests++;
      if (c_cur.act !== c_cur.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", tag_name(c_cur.tag), c_cur.act, c_cur.exp);
      end
    end
    if (update_en === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_update: got idx=%0d key=%0h valid=%0b, expected no update",
                 update_idx, update_key, update_valid);
      end else begin
        e_cur = sb.pop_front();
        if (update_idx !== e_cur.idx || update_key !== e_cur.key ||
            update_valid !== e_cur.vld || (e_cur.chk_fill && fill_idx !== e_cur.idx)) begin
          n_fail++;
          $display("FAIL update: got idx=%0d key=%0h valid=%0b fill_idx=%0d, expected idx=%0d key=%0h valid=%0b",
                   update_idx, update_key, update_valid, fill_idx, e_cur.idx, e_cur.key, e_cur.vld);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int tag, input logic [63:0] act, input logic [63:0] exp);
    cq.push_back('{tag: tag, act: act, exp: exp});
  endtask

  task automatic push_upd(input logic [IW-1:0] idx, input logic [KW-1:0] key,
                          input logic vld, input logic chk_fill);
    sb.push_back('{idx: idx, key: key, vld: vld, chk_fill: chk_fill});
  endtask

  task automatic do_fill(input logic [KW-1:0] key, input logic [IW-1:0] exp_idx);
    fill_req = 1'b1;
    fill_key = key;
    #1;
    check(7, 64'(fill_ready), 64'd1);
    push_upd(exp_idx, key, 1'b1, 1'b1);
    tick();
    fill_req = 1'b0;
  endtask

  task automatic push_flush();
    for (int i = 0; i < N; i++) push_upd(IW'(i), '0, 1'b0, 1'b0);
  endtask

  logic [KW-1:0] keys [4];

  initial begin
    keys[0] = 32'hA0A0_0001;
    keys[1] = 32'hB0B0_0002;
    keys[2] = 32'hC0C0_0003;
    keys[3] = 32'hD0D0_0004;

    reset     = 1'b0;
    fill_req  = 1'b0;
    fill_key  = '0;
    touch_en  = 1'b0;
    touch_idx = '0;
    inval_en  = 1'b0;
    inval_idx = '0;
    flush_req = 1'b0;
    repeat (3) tick();

    check(0, 64'(update_en),    64'd0);
    check(1, 64'(update_valid), 64'd0);
    check(2, 64'(update_idx),   64'd0);
    check(3, 64'(update_key),   64'd0);
    check(4, 64'(fill_idx),     64'd0);
    check(5, 64'(flush_busy),   64'd0);
    check(6, 64'(fill_ready),   64'd0);

    reset = 1'b1;
    #1;
    check(7, 64'(fill_ready), 64'd1);

    // Back-to-back fills into an empty CAM take slots 0..3.
    for (int i = 0; i < 4; i++) begin
      fill_req = 1'b1;
      fill_key = keys[i];
      #1;
      check(7, 64'(fill_ready), 64'd1);
      push_upd(IW'(i), keys[i], 1'b1, 1'b1);
      tick();
    end
    fill_req = 1'b0;
    tick();

    // All valid, tree root=0 node1=0: victim is slot 0.
    do_fill(32'hEEEE_0005, 2'd0);
    tick();

    // Invalidate slot 1, then a fill reuses the free slot.
    inval_en  = 1'b1;
    inval_idx = 2'd1;
    #1;
    check(7, 64'(fill_ready), 64'd0);
    push_upd(2'd1, '0, 1'b0, 1'b0);
    tick();
    inval_en = 1'b0;
    do_fill(32'hFFFF_0006, 2'd1);
    tick();

    // Flush with all valid; a fill held throughout lands in slot 0 afterwards.
    flush_req = 1'b1;
    #1;
    check(7, 64'(fill_ready), 64'd0);
    push_flush();
    tick();
    flush_req = 1'b0;
    fill_req  = 1'b1;
    fill_key  = 32'h6666_0007;
    for (int k = 0; k < 4; k++) begin
      #1;
      check(8, 64'(flush_busy), 64'd1);
      check(7, 64'(fill_ready), 64'd0);
      tick();
    end
    check(8, 64'(flush_busy), 64'd0);
    check(7, 64'(fill_ready), 64'd1);
    push_upd(2'd0, 32'h6666_0007, 1'b1, 1'b1);
    tick();
    fill_req = 1'b0;

    // Refill 1..3, touch slot 0, next victim is slot 2.
    do_fill(32'h1111_0008, 2'd1);
    do_fill(32'h2222_0009, 2'd2);
    do_fill(32'h3333_000A, 2'd3);
    touch_en  = 1'b1;
    touch_idx = 2'd0;
    tick();
    touch_en = 1'b0;
    do_fill(32'h4444_000B, 2'd2);
    tick();

    // Flush, invalidate and fill together: only the flush happens.
    flush_req = 1'b1;
    inval_en  = 1'b1;
    inval_idx = 2'd2;
    fill_req  = 1'b1;
    fill_key  = 32'h5555_000C;
    #1;
    check(7, 64'(fill_ready), 64'd0);
    push_flush();
    tick();
    flush_req = 1'b0;
    inval_en  = 1'b0;
    fill_req  = 1'b0;
    repeat (4) tick();
    check(8, 64'(flush_busy), 64'd0);
    do_fill(32'h7777_000D, 2'd0);
    tick();

    // Reset during the second flush cycle aborts the sequence.
    flush_req = 1'b1;
    push_upd(2'd0, '0, 1'b0, 1'b0);
    tick();
    flush_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check(9, 64'(update_en),  64'd0);
    check(5, 64'(flush_busy), 64'd0);
    check(6, 64'(fill_ready), 64'd0);
    reset = 1'b1;
    do_fill(32'h8888_000E, 2'd0);

    for (int w = 0; w < 20 && sb.size() > 0; w++) tick();
    check(10, 64'(sb.size()), 64'd0);
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
